// File: rtl/cla16_result_stage.sv
// Registered result/status stage behind the 16-bit CLA adder: 2-entry skid buffer
// for {flags, sum}, plus sticky carry/overflow bits and a saturating overflow counter.
module cla16_result_stage #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_z,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_parity,
  input  logic             in_sign,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_z,
  output logic [4:0]       out_flags,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_sticky
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]   state_q, state_d;
  logic [W+4:0] main_q, main_d;
  logic [W+4:0] skid_q, skid_d;
  logic [W+4:0] in_payload;
  logic         accept, deliver;

  logic             sticky_carry_d, sticky_ovf_d;
  logic [CNT_W-1:0] ovf_count_d;

  assign in_payload = {in_overflow, in_sign, in_parity, in_zero, in_carry, in_z};

  // in_ready comes from the state register only, so out_ready never reaches the producer.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  assign out_z     = main_q[W-1:0];
  assign out_flags = main_q[W+4:W];

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = in_payload;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_d = in_payload;
        end else if (accept) begin
          skid_d  = in_payload;
          state_d = TWO;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // An accept in the same cycle as clr_sticky still records its own event.
  always_comb begin
    sticky_carry_d = clr_sticky ? 1'b0 : sticky_carry;
    sticky_ovf_d   = clr_sticky ? 1'b0 : sticky_ovf;
    ovf_count_d    = clr_sticky ? '0 : ovf_count;
    if (accept) begin
      if (in_carry) sticky_carry_d = 1'b1;
      if (in_overflow) begin
        sticky_ovf_d = 1'b1;
        if (clr_sticky) begin
          ovf_count_d = CNT_W'(1);
        end else if (ovf_count != CntMax) begin
          ovf_count_d = ovf_count + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_q       <= '0;
      skid_q       <= '0;
      sticky_carry <= 1'b0;
      sticky_ovf   <= 1'b0;
      ovf_count    <= '0;
    end else begin
      state_q      <= state_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      sticky_carry <= sticky_carry_d;
      sticky_ovf   <= sticky_ovf_d;
      ovf_count    <= ovf_count_d;
    end
  end

endmodule
